ib_vnu_lut_loader: RTL and testbench

Iteration-update loader that sits directly upstream of the partial-VNU LUT stage and drives its RAM write port (`page_addr_ram`, `ram_write_data_1`, `ib_ram_we`). On each `load_start` it accepts one full LUT image, `PAGE_NUM` words, from a valid/ready stream. It writes the words page-by-page into the selected multi-frame half of the IB-VNU RAM. It then reports completion and, optionally, maintains an iteration counter so the decoder knows which iteration's LUT is resident.

---
 rtl/ib_vnu_lut_loader.sv | 107 ++++++++++
 tb/tb_ib_vnu_lut_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ib_vnu_lut_loader.sv
// Streams one PAGE_NUM-word LUT image into the selected multi-frame half of the IB-VNU RAM.
// Optional iteration counter is built only when IB_LOADER_ITER_CNT_EN is defined.
module ib_vnu_lut_loader #(
    parameter int ENTRY_ADDR    = 7,
    parameter int BANK_NUM      = 2,
    parameter int LUT_PORT_SIZE = 4,
    parameter int ITER_MAX      = 10,
    parameter int ITER_WIDTH    = 4
) (
    input  logic                              write_clk,
    input  logic                              rstn,
    input  logic                              load_start,
    input  logic                              frame_sel,
    input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_data,
    input  logic                              lut_valid,
    output logic                              lut_ready,
    output logic [ENTRY_ADDR-1:0]             page_addr_ram,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
    output logic                              ib_ram_we,
    output logic                              busy,
    output logic                              load_done,
    output logic [ITER_WIDTH-1:0]             iter_cnt
);

    localparam int PAGE_BITS = ENTRY_ADDR - 1;
    localparam int DATA_W    = LUT_PORT_SIZE * BANK_NUM;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (ITER_MAX < 1 || ITER_MAX > (2 ** ITER_WIDTH)) begin : g_param_check
        $error("ITER_MAX must lie in 1..2**ITER_WIDTH");
    end

    logic [1:0]            state_q, state_d;
    logic [PAGE_BITS-1:0]  page_idx_q;
    logic                  frame_q;
    logic [ENTRY_ADDR-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  we_q;
    logic                  handshake;
    logic                  last_page;

    assign handshake = lut_valid && (state_q == LOAD);
    assign last_page = (page_idx_q == {PAGE_BITS{1'b1}});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (handshake && last_page) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            page_idx_q <= '0;
            frame_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= handshake;
            // frame_sel is only sampled here, so a start request during a load cannot retarget it
            if (state_q == IDLE && load_start) begin
                frame_q    <= frame_sel;
                page_idx_q <= '0;
            end
            if (handshake) begin
                addr_q     <= {frame_q, page_idx_q};
                data_q     <= lut_data;
                page_idx_q <= page_idx_q + 1'b1;
            end
        end
    end

`ifdef IB_LOADER_ITER_CNT_EN
    logic [ITER_WIDTH-1:0] iter_q;

    // Updated alongside the final write so the new count is visible in the DONE cycle
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            iter_q <= '0;
        end else if (handshake && last_page) begin
            if (iter_q == ITER_WIDTH'(ITER_MAX - 1)) iter_q <= '0;
            else                                    iter_q <= iter_q + ITER_WIDTH'(1);
        end
    end

    assign iter_cnt = iter_q;
`else
    assign iter_cnt = '0;
`endif

    assign lut_ready        = (state_q == LOAD);
    assign busy             = (state_q != IDLE);
    assign load_done        = (state_q == DONE);
    assign page_addr_ram    = addr_q;
    assign ram_write_data_1 = data_q;
    assign ib_ram_we        = we_q;

endmodule

// File: tb/tb_ib_vnu_lut_loader.sv
// Directed bench for ib_vnu_lut_loader: full loads, backpressure, ignored starts, counter wrap and
// mid-load reset. Expected iter_cnt follows IB_LOADER_ITER_CNT_EN.
module tb_ib_vnu_lut_loader;

    logic       write_clk = 1'b0;
    logic       rstn      = 1'b0;
    logic       load_start = 1'b0;
    logic       frame_sel  = 1'b0;
    logic [7:0] lut_data   = '0;
    logic       lut_valid  = 1'b0;
    logic       lut_ready;
    logic [6:0] page_addr_ram;
    logic [7:0] ram_write_data_1;
    logic       ib_ram_we;
    logic       busy;
    logic       load_done;
    logic [3:0] iter_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_loads  = 0;

    ib_vnu_lut_loader dut (
        .write_clk        (write_clk),
        .rstn             (rstn),
        .load_start       (load_start),
        .frame_sel        (frame_sel),
        .lut_data         (lut_data),
        .lut_valid        (lut_valid),
        .lut_ready        (lut_ready),
        .page_addr_ram    (page_addr_ram),
        .ram_write_data_1 (ram_write_data_1),
        .ib_ram_we        (ib_ram_we),
        .busy             (busy),
        .load_done        (load_done),
        .iter_cnt         (iter_cnt)
    );

    always #5 write_clk = ~write_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_iter(input int loads);
`ifdef IB_LOADER_ITER_CNT_EN
        return 4'(loads % 10);
`else
        return 4'(loads * 0);
`endif
    endfunction

    function automatic logic [7:0] word_of(input logic frame, input int page);
        logic [7:0] p;
        p = 8'(page);
        return frame ? (8'hFF - p) : p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(lut_ready), 0);
        check({tag, "_we"}, 32'(ib_ram_we), 0);
        check({tag, "_addr"}, 32'(page_addr_ram), 0);
        check({tag, "_data"}, 32'(ram_write_data_1), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(load_done), 0);
        check({tag, "_iter"}, 32'(iter_cnt), 0);
    endtask

    // One load; gaps drops lut_valid every third cycle, start_at re-asserts load_start at that page,
    // abort_at pulls rstn low just before that page's handshake.
    task automatic do_load(input logic frame, input bit gaps, input int start_at, input int abort_at);
        int page;
        int cyc;
        logic v;
        logic [6:0] last_a;
        logic [7:0] last_d;
        page   = 0;
        cyc    = 0;
        last_a = '0;
        last_d = '0;
        @(negedge write_clk);
        load_start = 1'b1;
        frame_sel  = frame;
        lut_valid  = 1'b1;
        lut_data   = 8'h5A;
        @(negedge write_clk);
        cyc        = 1;
        load_start = 1'b0;
        frame_sel  = ~frame;
        check("start_ready", 32'(lut_ready), 1);
        check("start_busy", 32'(busy), 1);
        check("start_no_we", 32'(ib_ram_we), 0);
        while (page < 64 && cyc < 400) begin
            if (page == abort_at) begin
                lut_valid = 1'b0;
                rstn = 1'b0;
                #1;
                check_reset_outputs("abort");
                n_loads = 0;
                @(negedge write_clk);
                rstn = 1'b1;
                return;
            end
            v = gaps ? ((cyc % 3) != 0) : 1'b1;
            lut_valid = v;
            lut_data  = word_of(frame, page);
            if (page == start_at) begin
                load_start = 1'b1;
                frame_sel  = ~frame;
            end
            @(negedge write_clk);
            cyc++;
            load_start = 1'b0;
            if (v) begin
                last_a = {frame, 6'(page)};
                last_d = word_of(frame, page);
                check("wr_we", 32'(ib_ram_we), 1);
                check("wr_addr", 32'(page_addr_ram), 32'(last_a));
                check("wr_data", 32'(ram_write_data_1), 32'(last_d));
                page++;
                if (page == 64) begin
                    n_loads++;
                    check("done_pulse", 32'(load_done), 1);
                    check("done_busy", 32'(busy), 1);
                    check("done_ready", 32'(lut_ready), 0);
                    check("done_iter", 32'(iter_cnt), 32'(exp_iter(n_loads)));
                end else begin
                    check("load_ready", 32'(lut_ready), 1);
                    check("load_no_done", 32'(load_done), 0);
                end
            end else begin
                check("gap_we", 32'(ib_ram_we), 0);
                if (page > 0) begin
                    check("gap_addr_hold", 32'(page_addr_ram), 32'(last_a));
                    check("gap_data_hold", 32'(ram_write_data_1), 32'(last_d));
                end
            end
        end
        lut_valid = 1'b0;
        if (page < 64) check("load_timeout", 32'(page), 64);
        @(negedge write_clk);
        cyc++;
        check("idle_busy", 32'(busy), 0);
        check("idle_we", 32'(ib_ram_we), 0);
        check("idle_done", 32'(load_done), 0);
        check("idle_ready", 32'(lut_ready), 0);
        check("idle_iter", 32'(iter_cnt), 32'(exp_iter(n_loads)));
        if (!gaps) check("load_cycles", 32'(cyc), 66);
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        #20;
        rstn = 1'b1;

        do_load(1'b0, 1'b0, -1, -1);
        do_load(1'b1, 1'b1, -1, -1);
        do_load(1'b1, 1'b0, 20, -1);

        // Stray valid pulses while idle must not consume or write anything
        for (int i = 0; i < 4; i++) begin
            @(negedge write_clk);
            lut_valid = (i % 2) == 0;
            lut_data  = 8'hC3;
            @(negedge write_clk);
            lut_valid = 1'b0;
            check("stray_we", 32'(ib_ram_we), 0);
            check("stray_ready", 32'(lut_ready), 0);
            check("stray_busy", 32'(busy), 0);
        end

        for (int l = 4; l <= 10; l++) begin
            do_load(1'(l % 2), 1'b0, -1, -1);
            if (l == 9)  check("iter_after_9", 32'(iter_cnt), 32'(exp_iter(9)));
            if (l == 10) check("iter_after_10", 32'(iter_cnt), 32'(exp_iter(10)));
        end

        do_load(1'b0, 1'b0, -1, 30);
        do_load(1'b0, 1'b0, -1, -1);
        check("iter_after_reload", 32'(iter_cnt), 32'(exp_iter(1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
